// File: rtl/mem_access_stage.sv
// Memory-access stage: takes one load/store from execute, drives a word-addressed
// data memory with variable-latency ack, and returns loads on the regfile load port.
//
// state | meaning
// IDLE  | ready for a new operation from execute
// REQ   | request held on the memory bus until ack or timeout
// WB    | one-cycle load writeback to the regfile
module mem_access_stage #(
  parameter int ADDR_W      = 11,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              is_byte,
  input  logic [31:0]       addr,
  input  logic [31:0]       st_data,
  input  logic [3:0]        rd_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [3:0]        mem_byte_en,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       w_data_ldr,
  output logic [3:0]        w_addr_ldr,
  output logic              w_en_ldr,
  output logic              pending_valid,
  output logic [3:0]        pending_rd,
  output logic              err
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WB} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_load;
  logic              r_store;
  logic              r_byte;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_st_data;
  logic [3:0]        r_rd;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_ld_data;
  logic              r_err;

  logic              w_accept;
  logic              w_tc;
  logic              w_timeout;
  logic [1:0]        w_lane;
  logic [31:0]       w_rot;
  logic [7:0]        w_byte_sel;
  logic [31:0]       w_ld_data;
  logic              w_unused_addr;

  // Upper address bits fall outside the data memory and are ignored.
  assign w_unused_addr = ^addr[31:ADDR_W+2];

  assign w_accept  = in_valid && (r_state == S_IDLE) && (is_load || is_store);
  assign w_tc      = (r_cnt == '0);
  assign w_timeout = (r_state == S_REQ) && !mem_ack && w_tc;
  assign w_lane    = r_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_REQ;
      S_REQ: begin
        if (mem_ack)   w_next = r_load ? S_WB : S_IDLE;
        else if (w_tc) w_next = S_IDLE;
      end
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ARM unaligned word load: rotate right by 8*lane; byte load picks one lane.
  always_comb begin
    w_rot      = mem_rdata;
    w_byte_sel = mem_rdata[7:0];
    case (w_lane)
      2'd0: begin w_rot = mem_rdata;                           w_byte_sel = mem_rdata[7:0];   end
      2'd1: begin w_rot = {mem_rdata[7:0],  mem_rdata[31:8]};  w_byte_sel = mem_rdata[15:8];  end
      2'd2: begin w_rot = {mem_rdata[15:0], mem_rdata[31:16]}; w_byte_sel = mem_rdata[23:16]; end
      default: begin w_rot = {mem_rdata[23:0], mem_rdata[31:24]}; w_byte_sel = mem_rdata[31:24]; end
    endcase
    w_ld_data = r_byte ? {24'h0, w_byte_sel} : w_rot;
  end

  // Timeout is a down-counter loaded at accept; terminal count at zero ends REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load    <= 1'b0;
      r_store   <= 1'b0;
      r_byte    <= 1'b0;
      r_addr    <= '0;
      r_st_data <= '0;
      r_rd      <= '0;
      r_cnt     <= '0;
      r_ld_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (w_accept) begin
        r_load    <= is_load;
        r_store   <= is_store && !is_load;
        r_byte    <= is_byte;
        r_addr    <= addr[ADDR_W+1:0];
        r_st_data <= st_data;
        r_rd      <= rd_addr;
        r_cnt     <= CNT_W'(ACK_TIMEOUT - 1);
      end else if ((r_state == S_REQ) && !mem_ack && !w_tc) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if ((r_state == S_REQ) && mem_ack && r_load) begin
        r_ld_data <= w_ld_data;
      end
    end
  end

  always_comb begin
    in_ready      = (r_state == S_IDLE);
    mem_addr      = '0;
    mem_rd_en     = 1'b0;
    mem_wr_en     = 1'b0;
    mem_byte_en   = 4'h0;
    mem_wdata     = 32'h0;
    w_data_ldr    = 32'h0;
    w_addr_ldr    = 4'h0;
    w_en_ldr      = 1'b0;
    pending_valid = 1'b0;
    pending_rd    = 4'h0;
    err           = r_err;
    case (r_state)
      S_REQ: begin
        mem_addr      = r_addr[ADDR_W+1:2];
        mem_rd_en     = r_load;
        mem_wr_en     = r_store;
        pending_valid = r_load;
        pending_rd    = r_load ? r_rd : 4'h0;
        if (r_store) begin
          mem_wdata = r_byte ? {4{r_st_data[7:0]}} : r_st_data;
          if (!r_byte) begin
            mem_byte_en = 4'hF;
          end else begin
            case (w_lane)
              2'd0:    mem_byte_en = 4'b0001;
              2'd1:    mem_byte_en = 4'b0010;
              2'd2:    mem_byte_en = 4'b0100;
              default: mem_byte_en = 4'b1000;
            endcase
          end
        end
      end
      S_WB: begin
        w_en_ldr      = 1'b1;
        w_data_ldr    = r_ld_data;
        w_addr_ldr    = r_rd;
        pending_valid = 1'b1;
        pending_rd    = r_rd;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, randomized ops against a
// spec-level model, and hand sequences for timeout and mid-operation reset.
module tb_mem_access_stage;

  localparam int ADDR_W      = 11;
  localparam int ACK_TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              is_load;
  logic              is_store;
  logic              is_byte;
  logic [31:0]       addr;
  logic [31:0]       st_data;
  logic [3:0]        rd_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [3:0]        mem_byte_en;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic [31:0]       w_data_ldr;
  logic [3:0]        w_addr_ldr;
  logic              w_en_ldr;
  logic              pending_valid;
  logic [3:0]        pending_rd;
  logic              err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_stage #(.ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .is_load(is_load), .is_store(is_store), .is_byte(is_byte),
    .addr(addr), .st_data(st_data), .rd_addr(rd_addr),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .w_data_ldr(w_data_ldr), .w_addr_ldr(w_addr_ldr), .w_en_ldr(w_en_ldr),
    .pending_valid(pending_valid), .pending_rd(pending_rd), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ld;
    bit          st;
    bit          bt;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rdat;
    logic [3:0]  rd;
    int          waits;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit ld, bit st, bit bt, logic [31:0] a, logic [31:0] sd,
                              logic [31:0] rdat, logic [3:0] rd, int waits,
                              logic [31:0] maddr, logic [3:0] be, logic [31:0] wd,
                              logic [31:0] wb);
    vec_t v;
    v.ld = ld; v.st = st; v.bt = bt; v.a = a; v.sd = sd; v.rdat = rdat; v.rd = rd;
    v.waits = waits; v.exp_maddr = maddr; v.exp_be = be; v.exp_wdata = wd; v.exp_wb = wb;
    return v;
  endfunction

  // Reference model: derives expectations from address/lane arithmetic.
  function automatic vec_t model(bit ld, bit st, bit bt, logic [31:0] a, logic [31:0] sd,
                                 logic [31:0] rdat, logic [3:0] rd, int waits);
    vec_t        v;
    int          lane;
    logic [63:0] dbl;
    logic [63:0] shifted;
    lane    = int'(a % 4);
    dbl     = {rdat, rdat};
    shifted = dbl >> (8 * lane);
    v = mk(ld, st, bt, a, sd, rdat, rd, waits, 32'h0, 4'h0, 32'h0, 32'h0);
    v.exp_maddr = (a / 4) % (32'd1 << ADDR_W);
    v.exp_be    = bt ? 4'(1 << lane) : 4'hF;
    v.exp_wdata = bt ? sd[7:0] * 32'h01010101 : sd;
    v.exp_wb    = bt ? ((rdat >> (8 * lane)) & 32'hFF) : shifted[31:0];
    return v;
  endfunction

  task automatic apply(input vec_t v);
    bit act_op;
    bit st_only;
    act_op  = v.ld || v.st;
    st_only = v.st && !v.ld;
    @(negedge clk);
    check("ready_before_op", in_ready, 1);
    in_valid = 1; is_load = v.ld; is_store = v.st; is_byte = v.bt;
    addr = v.a; st_data = v.sd; rd_addr = v.rd;
    @(negedge clk);
    in_valid = 0; is_load = 0; is_store = 0; is_byte = 0;
    addr = $urandom; st_data = $urandom; rd_addr = 4'($urandom);
    if (!act_op) begin
      check("noop_rd_en", mem_rd_en, 0);
      check("noop_wr_en", mem_wr_en, 0);
      check("noop_ready", in_ready, 1);
      return;
    end
    for (int i = 0; i <= v.waits; i++) begin
      check("req_rd_en", mem_rd_en, v.ld);
      check("req_wr_en", mem_wr_en, st_only);
      check("req_mem_addr", mem_addr, v.exp_maddr);
      if (st_only) begin
        check("req_byte_en", mem_byte_en, v.exp_be);
        check("req_wdata", mem_wdata, v.exp_wdata);
      end
      check("req_pending_valid", pending_valid, v.ld);
      if (v.ld) check("req_pending_rd", pending_rd, v.rd);
      check("req_ready", in_ready, 0);
      check("req_w_en", w_en_ldr, 0);
      mem_ack   = (i == v.waits);
      mem_rdata = (i == v.waits) ? v.rdat : $urandom;
      @(negedge clk);
    end
    mem_ack = 0; mem_rdata = $urandom;
    if (v.ld) begin
      check("wb_w_en", w_en_ldr, 1);
      check("wb_data", w_data_ldr, v.exp_wb);
      check("wb_addr", w_addr_ldr, v.rd);
      check("wb_pending_valid", pending_valid, 1);
      check("wb_pending_rd", pending_rd, v.rd);
      check("wb_ready", in_ready, 0);
      @(negedge clk);
    end
    check("done_w_en", w_en_ldr, 0);
    check("done_ready", in_ready, 1);
    check("done_pending", pending_valid, 0);
    check("done_rd_en", mem_rd_en, 0);
    check("done_wr_en", mem_wr_en, 0);
    check("done_err", err, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, in_ready, 1);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_rd_en"}, mem_rd_en, 0);
    check({tag, "_wr_en"}, mem_wr_en, 0);
    check({tag, "_byte_en"}, mem_byte_en, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_w_data"}, w_data_ldr, 0);
    check({tag, "_w_addr"}, w_addr_ldr, 0);
    check({tag, "_w_en"}, w_en_ldr, 0);
    check({tag, "_pending"}, pending_valid, 0);
    check({tag, "_pending_rd"}, pending_rd, 0);
    check({tag, "_err"}, err, 0);
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = mk(1, 0, 0, 32'h0000_0104, 32'h0, 32'hDEADBEEF, 4'd3, 0,
                32'h041, 4'h0, 32'h0, 32'hDEADBEEF);
    tbl[1] = mk(0, 1, 1, 32'h0000_0022, 32'h0000_00A5, 32'h0, 4'd2, 3,
                32'h008, 4'b0100, 32'hA5A5A5A5, 32'h0);
    tbl[2] = mk(1, 0, 0, 32'h0000_0001, 32'h0, 32'h11223344, 4'd5, 0,
                32'h000, 4'h0, 32'h0, 32'h44112233);
    tbl[3] = mk(1, 0, 1, 32'h0000_0003, 32'h0, 32'h11223344, 4'd15, 1,
                32'h000, 4'h0, 32'h0, 32'h00000011);
    tbl[4] = mk(1, 1, 0, 32'h0000_0208, 32'h12345678, 32'hCAFEF00D, 4'd7, 2,
                32'h082, 4'h0, 32'h0, 32'hCAFEF00D);
    tbl[5] = mk(0, 0, 0, 32'h0000_0010, 32'h0, 32'h0, 4'd1, 0,
                32'h0, 4'h0, 32'h0, 32'h0);
    tbl[6] = mk(0, 1, 0, 32'hFFFF_F00E, 32'h0BADC0DE, 32'h0, 4'd0, 1,
                32'h403, 4'hF, 32'h0BADC0DE, 32'h0);
    tbl[7] = mk(1, 0, 1, 32'h0000_0005, 32'h0, 32'hA1B2C3D4, 4'd9, 0,
                32'h001, 4'h0, 32'h0, 32'h000000C3);
    tbl[8] = mk(1, 0, 0, 32'h0000_000A, 32'h0, 32'hA1B2C3D4, 4'd12, 4,
                32'h002, 4'h0, 32'h0, 32'hC3D4A1B2);

    rst = 1; in_valid = 0; is_load = 0; is_store = 0; is_byte = 0;
    addr = 0; st_data = 0; rd_addr = 0; mem_rdata = 0; mem_ack = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    check_all_zero("reset");

    foreach (tbl[i]) apply(tbl[i]);

    // Timeout: load with no ack for the full window.
    @(negedge clk);
    in_valid = 1; is_load = 1; addr = 32'h0000_0040; rd_addr = 4'd6;
    @(negedge clk);
    in_valid = 0; is_load = 0;
    for (int i = 0; i < ACK_TIMEOUT; i++) begin
      check("to_rd_en", mem_rd_en, 1);
      check("to_pending", pending_valid, 1);
      check("to_err_early", err, 0);
      @(negedge clk);
    end
    check("to_err", err, 1);
    check("to_rd_en_drop", mem_rd_en, 0);
    check("to_pending_clear", pending_valid, 0);
    check("to_w_en", w_en_ldr, 0);
    check("to_ready", in_ready, 1);
    @(negedge clk);
    check("to_err_one_cycle", err, 0);
    check("to_w_en_after", w_en_ldr, 0);

    // Reset in REQ, then a late ack arriving in IDLE.
    @(negedge clk);
    in_valid = 1; is_load = 1; addr = 32'h0000_0300; rd_addr = 4'd4;
    @(negedge clk);
    in_valid = 0; is_load = 0;
    @(negedge clk);
    check("mid_rd_en", mem_rd_en, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_all_zero("midrst");
    mem_ack = 1; mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    mem_ack = 0;
    check("late_ack_w_en", w_en_ldr, 0);
    check("late_ack_rd_en", mem_rd_en, 0);
    check("late_ack_ready", in_ready, 1);
    check("late_ack_err", err, 0);

    for (int n = 0; n < 40; n++) begin
      int   kind;
      bit   ld;
      bit   st;
      vec_t v;
      kind = $urandom_range(0, 9);
      ld = (kind < 5) || (kind == 9);
      st = (kind >= 5);
      if (kind == 8) begin ld = 0; st = 0; end
      v = model(ld, st, 1'($urandom), $urandom, $urandom, $urandom,
                4'($urandom), $urandom_range(0, 4));
      apply(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
